// File: rtl/score_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : score_fetch_seq
//  Description : Steps a score ROM address from a start to an end address at a
//                tempo-selected beat rate, optionally looping the section, and
//                captures each ROM code into note_code with a valid strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_fetch_seq #(
  parameter int ADDR_W   = 10,
  parameter int CODE_W   = 4,
  parameter int TICK_DIV = 6250000,
  parameter int ROM_LAT  = 1
) (
  input  logic              ext_clk_25m,
  input  logic              ext_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [1:0]        tempo,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CODE_W-1:0] rom_q,
  output logic [CODE_W-1:0] note_code,
  output logic              note_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit so the counter can also hold the full period value.
  localparam int CNT_W = $clog2(TICK_DIV) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] lat_start_q, lat_start_d;
  logic [ADDR_W-1:0] lat_end_q, lat_end_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  // Bit k set means an address update happened k clocks ago; the top bit
  // marks the cycle in which rom_q holds the data for that update.
  logic [ROM_LAT:0]  pend_q, pend_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  period_sel;
  logic              start_ok;

  // Beat period for the currently requested tempo (tempo 3 runs as tempo 2).
  always_comb begin
    case (tempo)
      2'd0:    period_sel = CNT_W'(TICK_DIV);
      2'd1:    period_sel = CNT_W'(TICK_DIV / 2);
      default: period_sel = CNT_W'(TICK_DIV / 4);
    endcase
  end

  assign start_ok = (start_addr <= end_addr);

  // Next-state, address stepping, beat counting and ROM capture.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lat_start_d = lat_start_q;
    lat_end_d   = lat_end_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    pend_d      = {pend_q[ROM_LAT-1:0], 1'b0};
    code_d      = code_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;

    // Reads in flight complete regardless of PLAY/PAUSE.
    if (pend_q[ROM_LAT]) begin
      code_d  = rom_q;
      valid_d = 1'b1;
    end

    if (stop) begin
      state_d = IDLE;
      code_d  = '0;
      valid_d = 1'b0;
      pend_d  = '0;
    end else if (start && start_ok) begin
      // Restart drops reads belonging to the previous run.
      state_d     = PLAY;
      lat_start_d = start_addr;
      lat_end_d   = end_addr;
      addr_d      = start_addr;
      cnt_d       = '0;
      period_d    = period_sel;
      code_d      = code_q;
      valid_d     = 1'b0;
      pend_d      = '0;
      pend_d[0]   = 1'b1;
    end else begin
      err_d = start;
      case (state_q)
        PLAY: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (cnt_q == period_q - CNT_W'(1)) begin
            cnt_d    = '0;
            period_d = period_sel;
            if (addr_q < lat_end_q) begin
              addr_d    = addr_q + 1'b1;
              pend_d[0] = 1'b1;
            end else if (loop_en) begin
              addr_d    = lat_start_q;
              pend_d[0] = 1'b1;
            end else begin
              // Section finished: rest note, nothing left to capture.
              state_d = DONE;
              code_d  = '0;
              valid_d = 1'b0;
              pend_d  = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PAUSE: begin
          if (!pause) state_d = PLAY;
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      lat_start_q <= '0;
      lat_end_q   <= '0;
      cnt_q       <= '0;
      period_q    <= '0;
      pend_q      <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lat_start_q <= lat_start_d;
      lat_end_q   <= lat_end_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      pend_q      <= pend_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign rom_addr   = addr_q;
  assign note_code  = code_q;
  assign note_valid = valid_q;
  assign busy       = (state_q == PLAY) || (state_q == PAUSE);
  assign done       = (state_q == DONE);
  assign err        = err_q;

endmodule
`default_nettype wire

// File: doc/score_fetch_seq.md
SCORE_FETCH_SEQ -- requirements
Module: score_fetch_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning score ROM address width.
REQ-002 The block SHALL have parameter CODE_W, default 4, meaning score code width.
REQ-003 The block SHALL have parameter TICK_DIV, default 6250000, meaning clocks per beat at tempo 0 (4 Hz at 25 MHz); legal range 8 or more, divisible by 4.
REQ-004 The block SHALL have parameter ROM_LAT, default 1, meaning ROM read latency in clocks; legal values 1..3.
REQ-005 The block SHALL have ports ext_clk_25m, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port ext_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have ports start, stop and pause, each input, 1 bit: start and stop are one-cycle command pulses; pause is a level.
REQ-008 The block SHALL have ports loop_en (input, 1 bit) and tempo (input, 2 bits): repeat-section enable and speed select.
REQ-009 The block SHALL have ports start_addr and end_addr, each input, ADDR_W bits: first and last score addresses, inclusive.
REQ-010 The block SHALL have ports rom_addr (output, ADDR_W bits) and rom_q (input, CODE_W bits): ROM address and ROM data.
REQ-011 The block SHALL have ports note_code (output, CODE_W bits) and note_valid (output, 1 bit): current score code and its one-cycle update strobe.
REQ-012 The block SHALL have outputs busy, done and err, each 1 bit: busy means playing or paused; done and err are one-cycle pulses.

Function
REQ-013 The state machine SHALL have the states IDLE, PLAY, PAUSE and DONE.
REQ-014 Command priority SHALL be: stop first, then start, then pause.
REQ-015 IDLE + start with start_addr <= end_addr: latch both addresses, set rom_addr = start_addr, clear the beat counter, go to PLAY.
REQ-016 start with start_addr > end_addr SHALL be rejected: err = 1 for one cycle, state and outputs unchanged.
REQ-017 start in PLAY, PAUSE or DONE SHALL restart from the new start_addr, as in IDLE.
REQ-018 stop in any state: go to IDLE, set note_code = 0 (rest), discard in-flight ROM reads, done = 0.
REQ-019 PLAY: the beat counter increments every clock; a tick occurs when count = period-1, after which count wraps to 0.
REQ-020 The beat period SHALL be TICK_DIV>>tempo (tempo 3 behaves as 2); tempo is sampled only at a tick or at start.
REQ-021 On a tick with rom_addr < latched end: rom_addr increments by 1.
REQ-022 On a tick with rom_addr = latched end and loop_en = 1: rom_addr = latched start, with no gap cycle.
REQ-023 On a tick with rom_addr = latched end and loop_en = 0: go to DONE.
REQ-024 Address arithmetic SHALL be ADDR_W bits and SHALL never pass the latched end; end = 2^ADDR_W-1 SHALL not wrap to 0.
REQ-025 ROM capture: after each rom_addr change (including the start load), note_code <= rom_q exactly ROM_LAT+1 clocks later.
REQ-026 note_valid SHALL be 1 in the same cycle as each ROM capture into note_code, one pulse per address change.
REQ-027 PLAY + pause = 1 (and no stop or start): go to PAUSE; the beat counter freezes and note_code and rom_addr hold.
REQ-028 PAUSE + pause = 0: return to PLAY, resuming the count from its frozen value.
REQ-029 Captures already in flight when entering PAUSE SHALL still complete.
REQ-030 DONE SHALL last exactly one cycle: done = 1, note_code = 0, then go to IDLE.
REQ-031 busy SHALL be 1 exactly in PLAY and PAUSE.
REQ-032 Latched start and end SHALL be fixed while busy; changes on start_addr or end_addr take effect only at the next start.

Reset
REQ-033 While ext_rst_n = 0: state = IDLE; rom_addr, note_code, beat counter and latched addresses = 0; note_valid, busy, done and err = 0.
REQ-034 Reset asserted mid-play SHALL abort immediately, with no done pulse and no capture after release.
REQ-035 After ext_rst_n rises, the block SHALL wait in IDLE for start.

Verification (TICK_DIV=8, ROM_LAT=1, ROM data = address low 4 bits)
REQ-036 Basic play: start_addr=2, end_addr=4, loop_en=0, tempo=0, start pulse -> rom_addr 2,3,4 at 8-clock spacing; note_code 2,3,4, each 2 clocks after the address; done pulse 8 clocks after address 4; then IDLE with note_code=0.
REQ-037 Loop: same addresses with loop_en=1, run 40 clocks -> rom_addr sequence 2,3,4,2,3; done never asserts; busy stays 1.
REQ-038 Pause: pause=1 for 20 clocks at beat count 5 -> rom_addr and note_code frozen; after release the next tick arrives 3 clocks later.
REQ-039 Tempo and bad range: tempo=2 -> period 2 clocks; start with start_addr=9, end_addr=3 -> err pulse, busy stays 0.
REQ-040 Stop and reset mid-play: stop and start asserted in the same cycle -> IDLE with note_code=0; reset asserted during PLAY -> all outputs 0 asynchronously, no done pulse.
REQ-041 Boundary: start_addr = end_addr = 1023 with loop_en=1 -> rom_addr stays 1023 and note_valid pulses once per tick.
